// File: rtl/axi_sram_read_slave_pkg.sv
// Shared AXI read-channel encodings: burst types, response codes and word size.
// Used by axi_sram_read_slave, axi_burst_addr_gen and the cache-side merger.
package axi_sram_read_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-word-address generator for FIXED/INCR/WRAP bursts.
// Ports: addr/len/burst in; next_addr, wrap_bad (illegal WRAP length) out.
// AXI_WRAP_BURST_EN: when undefined, every WRAP is flagged and no mask logic exists.
module axi_burst_addr_gen
  import axi_sram_read_slave_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap_bad
);

  logic [ADDR_W-1:0] inc;

  // Word address: INCR wraps naturally modulo the window.
  assign inc = addr + ADDR_W'(1);

`ifdef AXI_WRAP_BURST_EN
  logic [ADDR_W-1:0] mask;

  // Legal wrap lengths are 2/4/8/16 beats, so len itself is the word mask.
  assign mask = ADDR_W'(len[3:0]);

  always_comb begin
    next_addr = addr;
    wrap_bad  = 1'b0;
    unique case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: begin
        next_addr = (addr & ~mask) | (inc & mask);
        wrap_bad  = !(len == 8'd1 || len == 8'd3 ||
                      len == 8'd7 || len == 8'd15);
      end
      default: next_addr = addr;
    endcase
  end
`else
  logic unused_len;

  assign unused_len = ^len;

  always_comb begin
    next_addr = addr;
    wrap_bad  = 1'b0;
    unique case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: wrap_bad = 1'b1;
      default:    next_addr = addr;
    endcase
  end
`endif

endmodule

// File: rtl/axi_sram_read_slave.sv
// AXI3 AR/R read responder in front of a synchronous-read SRAM (boot ROM/scratchpad).
// Ports: AR channel (arid..arvalid/arready), R channel (rid..rvalid/rready),
// SRAM port (ram_en, ram_addr, ram_rdata valid the cycle after ram_en).
// AXI_WRAP_BURST_EN: enables WRAP bursts; otherwise WRAP returns SLVERR.
module axi_sram_read_slave
  import axi_sram_read_slave_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
  parameter int          ID_W      = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_rdata
);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len;
  logic [1:0]        burst;
  logic [1:0]        err;
  logic [8:0]        fetch_cnt;
  logic              ar_hs;
  logic              r_hs;
  logic              issue;
  logic [ADDR_W-1:0] gen_addr;
  logic [7:0]        gen_len;
  logic [1:0]        gen_burst;
  logic [ADDR_W-1:0] gen_next;
  logic              wrap_bad;
  logic [31:0]       offset;
  logic              dec_err;
  logic              slv_err;
  logic [1:0]        ar_resp;

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // A beat slot is taken whenever the output register is free or draining;
  // error bursts take the same slots but never touch the SRAM.
  assign issue = (state == BURST) && (fetch_cnt != 9'd0) &&
                 (!rvalid || rready);

  assign ram_en   = aresetn && issue && (err == RESP_OKAY);
  assign ram_addr = addr;
  assign rdata    = (err == RESP_OKAY) ? ram_rdata : 32'd0;

  // In IDLE the generator classifies the incoming request; in BURST it
  // steps the latched address.
  assign gen_addr  = (state == IDLE) ? araddr[ADDR_W+1:2] : addr;
  assign gen_len   = (state == IDLE) ? arlen : len;
  assign gen_burst = (state == IDLE) ? arburst : burst;

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .addr     (gen_addr),
    .len      (gen_len),
    .burst    (gen_burst),
    .next_addr(gen_next),
    .wrap_bad (wrap_bad)
  );

  assign offset  = araddr - BASE_ADDR;
  assign dec_err = (araddr < BASE_ADDR) || (|offset[31:ADDR_W+2]);
  assign slv_err = (arsize != ARSIZE_WORD) || (arburst == 2'b11) ||
                   wrap_bad;
  assign ar_resp = dec_err ? RESP_DECERR :
                   slv_err ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (ar_hs) state_n = BURST;
      BURST:   if (r_hs && rlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= RESP_OKAY;
      rid       <= '0;
      addr      <= '0;
      len       <= '0;
      burst     <= BURST_FIXED;
      err       <= RESP_OKAY;
      fetch_cnt <= '0;
    end else begin
      arready <= (state_n == IDLE);
      if (ar_hs) begin
        rid       <= arid;
        addr      <= araddr[ADDR_W+1:2];
        len       <= arlen;
        burst     <= arburst;
        err       <= ar_resp;
        fetch_cnt <= {1'b0, arlen} + 9'd1;
      end
      if (issue) begin
        addr      <= gen_next;
        fetch_cnt <= fetch_cnt - 9'd1;
        rvalid    <= 1'b1;
        rlast     <= (fetch_cnt == 9'd1);
        rresp     <= err;
      end else if (r_hs) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Directed bench for axi_sram_read_slave with a behavioural sync SRAM.
// Follows AXI_WRAP_BURST_EN to pick the WRAP expectation.
module tb_axi_sram_read_slave;
  import axi_sram_read_slave_pkg::*;

  localparam int          ADDR_W = 12;
  localparam int          ID_W   = 4;
  localparam logic [31:0] BASE   = 32'h1fc0_0000;

  logic              clk = 1'b0;
  logic              aresetn;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata = 32'd0;

  always #5 clk = ~clk;

  axi_sram_read_slave #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .ID_W     (ID_W)
  ) dut (
    .aclk     (clk),
    .aresetn  (aresetn),
    .arid     (arid),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arvalid  (arvalid),
    .arready  (arready),
    .rid      (rid),
    .rdata    (rdata),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

  int n_run  = 0;
  int n_fail = 0;
  int exp_idx[$];

  function automatic logic [31:0] ref_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : {16'hA5A5, 16'(i)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string tag, input logic [ID_W-1:0] id,
                           input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit bp, input logic [1:0] resp);
    int beat, cyc, ens, bubbles, wait_c;
    logic [31:0] held, exp;
    bit stalled;
    wait_c = 0;
    while (!arready && wait_c < 20) begin
      tick();
      wait_c++;
    end
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    arid = id; araddr = addr; arlen = len;
    arsize = size; arburst = burst; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk({tag, "_arready_low"}, 32'(arready), 32'd0);
    beat = 0; cyc = 0; ens = 0; bubbles = 0;
    stalled = 1'b0; held = 32'd0;
    while (beat <= int'(len) && cyc < 300) begin
      rready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (ram_en) ens++;
      if (cyc == 0) chk({tag, "_lat_n1"}, 32'(rvalid), 32'd0);
      if (cyc == 1) chk({tag, "_lat_n2"}, 32'(rvalid), 32'd1);
      if (rvalid) begin
        if (stalled) chk({tag, "_hold"}, rdata, held);
        if (rready) begin
          exp = (resp == RESP_OKAY) ? ref_word(exp_idx[beat]) : 32'd0;
          chk($sformatf("%s_data%0d", tag, beat), rdata, exp);
          chk({tag, "_resp"}, 32'(rresp), 32'(resp));
          chk({tag, "_rid"}, 32'(rid), 32'(id));
          chk({tag, "_rlast"}, 32'(rlast), 32'(beat == int'(len)));
          beat++;
          stalled = 1'b0;
        end else begin
          chk({tag, "_stall_ram_en"}, 32'(ram_en), 32'd0);
          held = rdata;
          stalled = 1'b1;
        end
      end else if (cyc >= 1 && !bp) begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    rready = 1'b1;
    chk({tag, "_beats"}, 32'(beat), 32'(int'(len) + 1));
    chk({tag, "_ram_en_cnt"}, 32'(ens),
        (resp == RESP_OKAY) ? 32'(int'(len) + 1) : 32'd0);
    if (!bp) chk({tag, "_bubbles"}, 32'(bubbles), 32'd0);
    chk({tag, "_end_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_end_arready"}, 32'(arready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = ref_word(i);
    aresetn = 1'b0; arid = '0; araddr = '0; arlen = '0;
    arsize = ARSIZE_WORD; arburst = BURST_INCR; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) tick();
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    aresetn = 1'b1;
    tick();
    chk("rel_arready", 32'(arready), 32'd1);

    exp_idx = '{4};
    run_burst("single", 4'h5, BASE + 32'h10, 8'd0, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_OKAY);

    exp_idx = {};
    for (int i = 0; i < 16; i++) exp_idx.push_back(i);
    run_burst("incr16", 4'hA, BASE, 8'd15, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_OKAY);
    run_burst("bp16", 4'h3, BASE, 8'd15, ARSIZE_WORD,
              BURST_INCR, 1'b1, RESP_OKAY);

`ifdef AXI_WRAP_BURST_EN
    exp_idx = '{6, 7, 4, 5};
    run_burst("wrap4", 4'h6, BASE + 32'h18, 8'd3, ARSIZE_WORD,
              BURST_WRAP, 1'b0, RESP_OKAY);
`else
    run_burst("wrap4", 4'h6, BASE + 32'h18, 8'd3, ARSIZE_WORD,
              BURST_WRAP, 1'b0, RESP_SLVERR);
`endif
    run_burst("wrap_len3", 4'h1, BASE + 32'h18, 8'd2, ARSIZE_WORD,
              BURST_WRAP, 1'b0, RESP_SLVERR);

    run_burst("decerr_lo", 4'h7, 32'h0000_0000, 8'd3, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_DECERR);
    run_burst("decerr_hi", 4'h8, BASE + 32'h4000, 8'd0, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_DECERR);
    run_burst("size16", 4'h9, BASE, 8'd0, 3'b001,
              BURST_INCR, 1'b0, RESP_SLVERR);
    run_burst("burst11", 4'h2, BASE, 8'd1, ARSIZE_WORD,
              2'b11, 1'b0, RESP_SLVERR);

    exp_idx = '{2, 2, 2};
    run_burst("fixed", 4'hC, BASE + 32'h8, 8'd2, ARSIZE_WORD,
              BURST_FIXED, 1'b0, RESP_OKAY);
    exp_idx = '{4095, 0};
    run_burst("winwrap", 4'hD, BASE + 32'h3FFC, 8'd1, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_OKAY);
    exp_idx = '{4};
    run_burst("unalign", 4'hE, BASE + 32'h13, 8'd0, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_OKAY);

    arid = 4'hF; araddr = BASE; arlen = 8'd15;
    arsize = ARSIZE_WORD; arburst = BURST_INCR; arvalid = 1'b1;
    rready = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    tick();
    chk("mid_beat2_rvalid", 32'(rvalid), 32'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    tick();
    chk("mid_rel_arready", 32'(arready), 32'd1);
    chk("mid_rel_rvalid", 32'(rvalid), 32'd0);
    exp_idx = '{9, 10};
    run_burst("after_rst", 4'h4, BASE + 32'h24, 8'd1, ARSIZE_WORD,
              BURST_INCR, 1'b0, RESP_OKAY);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
